dcache_port_arbiter: RTL and testbench

- N-to-1 arbiter that merges NUM_PORTS CPU-side dcache request channels onto a single cache-side channel.
- Each channel uses the same addr/wdata/wmask/rw/valid/ready/rdata/rvalid protocol as the dcache interface.
- Read responses return in order; a port-ID tag FIFO routes each response back to the requester.
- Sits between the load/store functional units and the dcache.

---
 rtl/dcache_arb_pkg.sv | 43 ++++
 rtl/dcache_arb_tag_fifo.sv | 56 +++++
 rtl/dcache_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_dcache_port_arbiter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared constants and helpers for the dcache port arbiter.
// Default widths, rw encoding, and the round-robin pick function.
package dcache_arb_pkg;

   localparam int DCACHE_DATA_LENGTH = 32;
   localparam int DCACHE_ADDR_LENGTH = 32;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   // Widest request vector rr_pick handles; callers zero-extend narrower vectors.
   localparam int RR_MAX_PORTS = 32;

   // Round-robin pick: search starts just above the one-hot 'last' grant and wraps.
   // Requests above the caller's port count are zero, so wrapping modulo
   // RR_MAX_PORTS visits live ports in the same order as wrapping modulo the
   // real port count.
   function automatic logic [RR_MAX_PORTS-1:0] rr_pick(
      input logic [RR_MAX_PORTS-1:0] req,
      input logic [RR_MAX_PORTS-1:0] last
   );
      logic [RR_MAX_PORTS-1:0] gnt;
      logic [4:0]              last_idx;
      logic [4:0]              idx;
      logic                    found;
      gnt      = '0;
      last_idx = '0;
      idx      = '0;
      found    = 1'b0;
      for (int i = 0; i < RR_MAX_PORTS; i++) begin
         if (last[i[4:0]]) last_idx = i[4:0];
      end
      for (int k = 1; k <= RR_MAX_PORTS; k++) begin
         idx = last_idx + k[4:0];
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/dcache_arb_tag_fifo.sv
// Port-ID tag FIFO for the dcache arbiter.
// Holds the requester ID of each outstanding read so responses, which return
// in order, can be steered back. Head is readable combinationally so a
// response can be routed in the same cycle it pops.
module dcache_arb_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_reg == (PTR_W+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr_reg];

   // Tag storage write; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_reg] <= push_data;
   end

   // Pointers wrap naturally; the separate count disambiguates full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/dcache_port_arbiter.sv
// N-to-1 dcache request arbiter with in-order read response routing.
// Request path is combinational; a granted port stays granted while the cache
// stalls it. Optional macro DCACHE_ARB_FIXED_PRIO_EN switches from round-robin
// to fixed priority (lowest index wins).
module dcache_port_arbiter
   import dcache_arb_pkg::*;
#(
   parameter int NUM_PORTS       = 2,
   parameter int DATA_LENGTH     = DCACHE_DATA_LENGTH,
   parameter int ADDR_LENGTH     = DCACHE_ADDR_LENGTH,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             up_valid,
   output logic [NUM_PORTS-1:0]             up_ready,
   input  logic [NUM_PORTS*ADDR_LENGTH-1:0] up_addr,
   input  logic [NUM_PORTS*DATA_LENGTH-1:0] up_wdata,
   input  logic [NUM_PORTS*DATA_LENGTH-1:0] up_wmask,
   input  logic [NUM_PORTS-1:0]             up_rw,
   output logic [DATA_LENGTH-1:0]           up_rdata,
   output logic [NUM_PORTS-1:0]             up_rvalid,
   output logic                             dn_valid,
   input  logic                             dn_ready,
   output logic [ADDR_LENGTH-1:0]           dn_addr,
   output logic [DATA_LENGTH-1:0]           dn_wdata,
   output logic [DATA_LENGTH-1:0]           dn_wmask,
   output logic                             dn_rw,
   input  logic [DATA_LENGTH-1:0]           dn_rdata,
   input  logic                             dn_rvalid
);

   localparam int PID_W = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0] gnt_oh;
   logic [PID_W-1:0]     gnt_idx;
   logic                 handshake;
   logic                 lock_reg;
   logic                 lock_next;
   logic [PID_W-1:0]     lock_port_reg;
   logic [PID_W-1:0]     lock_port_next;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic [PID_W-1:0]     fifo_head;

`ifndef DCACHE_ARB_FIXED_PRIO_EN
   logic [NUM_PORTS-1:0] last_grant_reg;
`endif

   // Grant selection: a stalled grant is held, otherwise pick a new winner.
   always_comb begin
      gnt_oh = '0;
      if (lock_reg) begin
         gnt_oh[lock_port_reg] = 1'b1;
      end else begin
`ifdef DCACHE_ARB_FIXED_PRIO_EN
         for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (up_valid[i[PID_W-1:0]]) begin
               gnt_oh                 = '0;
               gnt_oh[i[PID_W-1:0]]   = 1'b1;
            end
         end
`else
         gnt_oh = NUM_PORTS'(rr_pick(RR_MAX_PORTS'(up_valid), RR_MAX_PORTS'(last_grant_reg)));
`endif
      end
   end

   // One-hot grant to binary port ID for payload muxing and tagging.
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt_oh[i[PID_W-1:0]]) gnt_idx = i[PID_W-1:0];
      end
   end

   assign dn_valid  = (|up_valid) & ~fifo_full & ~rst;
   assign handshake = dn_valid & dn_ready;
   assign dn_addr   = up_addr[int'(gnt_idx)*ADDR_LENGTH +: ADDR_LENGTH];
   assign dn_wdata  = up_wdata[int'(gnt_idx)*DATA_LENGTH +: DATA_LENGTH];
   assign dn_wmask  = up_wmask[int'(gnt_idx)*DATA_LENGTH +: DATA_LENGTH];
   assign dn_rw     = up_rw[gnt_idx];

   assign fifo_push = handshake & (dn_rw == RW_READ);
   assign fifo_pop  = dn_rvalid & ~fifo_empty & ~rst;
   assign up_rdata  = dn_rdata;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign up_ready[gi]  = gnt_oh[gi] & handshake;
         assign up_rvalid[gi] = fifo_pop & (fifo_head == PID_W'(gi));
      end
   endgenerate

   // Lock follows the presented request until the cache takes it.
   always_comb begin
      lock_next      = lock_reg;
      lock_port_next = lock_port_reg;
      if (handshake) begin
         lock_next = 1'b0;
      end else if (dn_valid) begin
         lock_next      = 1'b1;
         lock_port_next = gnt_idx;
      end
   end

   // Lock state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_reg      <= 1'b0;
         lock_port_reg <= '0;
      end else begin
         lock_reg      <= lock_next;
         lock_port_reg <= lock_port_next;
      end
   end

`ifndef DCACHE_ARB_FIXED_PRIO_EN
   // Round-robin pointer moves only when a request is actually accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_reg <= {1'b1, {(NUM_PORTS-1){1'b0}}};
      end else if (handshake) begin
         last_grant_reg <= gnt_oh;
      end
   end
`endif

   dcache_arb_tag_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (PID_W)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (gnt_idx),
      .pop       (fifo_pop),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Self-checking bench for dcache_port_arbiter (default round-robin build).
// Directed scenarios use hand-derived constants; a randomized run is checked
// against a queue-based reference model.
module tb_dcache_port_arbiter;

   localparam int NP = 2;
   localparam int AL = 32;
   localparam int DL = 32;
   localparam int MO = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP-1:0]    up_valid;
   logic [NP-1:0]    up_ready;
   logic [NP*AL-1:0] up_addr;
   logic [NP*DL-1:0] up_wdata;
   logic [NP*DL-1:0] up_wmask;
   logic [NP-1:0]    up_rw;
   logic [DL-1:0]    up_rdata;
   logic [NP-1:0]    up_rvalid;
   logic             dn_valid;
   logic             dn_ready;
   logic [AL-1:0]    dn_addr;
   logic [DL-1:0]    dn_wdata;
   logic [DL-1:0]    dn_wmask;
   logic             dn_rw;
   logic [DL-1:0]    dn_rdata;
   logic             dn_rvalid;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   dcache_port_arbiter #(
      .NUM_PORTS       (NP),
      .DATA_LENGTH     (DL),
      .ADDR_LENGTH     (AL),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .up_valid  (up_valid),
      .up_ready  (up_ready),
      .up_addr   (up_addr),
      .up_wdata  (up_wdata),
      .up_wmask  (up_wmask),
      .up_rw     (up_rw),
      .up_rdata  (up_rdata),
      .up_rvalid (up_rvalid),
      .dn_valid  (dn_valid),
      .dn_ready  (dn_ready),
      .dn_addr   (dn_addr),
      .dn_wdata  (dn_wdata),
      .dn_wmask  (dn_wmask),
      .dn_rw     (dn_rw),
      .dn_rdata  (dn_rdata),
      .dn_rvalid (dn_rvalid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_port(input int p, input logic v, input logic rw, input logic [AL-1:0] a);
      up_valid[p]           = v;
      up_rw[p]              = rw;
      up_addr[p*AL +: AL]   = a;
      up_wdata[p*DL +: DL]  = ~a;
      up_wmask[p*DL +: DL]  = a ^ 32'h5a5a_5a5a;
   endtask

   task automatic clear_inputs();
      up_valid  = '0;
      up_rw     = '0;
      up_addr   = '0;
      up_wdata  = '0;
      up_wmask  = '0;
      dn_ready  = 1'b0;
      dn_rdata  = '0;
      dn_rvalid = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      drive_port(0, 1'b1, 1'b0, 32'h10);
      drive_port(1, 1'b1, 1'b0, 32'h14);
      dn_ready  = 1'b1;
      dn_rvalid = 1'b1;
      tick();
      settle();
      tests_run++;
      if (dn_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dn_valid got=%b exp=0", dn_valid); end
      tests_run++;
      if (up_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_up_ready got=%b exp=00", up_ready); end
      tests_run++;
      if (up_rvalid !== 2'b00) begin tests_failed++; $display("FAIL reset_up_rvalid got=%b exp=00", up_rvalid); end
      tick();
      rst = 1'b0;
      dn_rvalid = 1'b0;
      settle();
      tests_run++;
      if (up_ready !== 2'b01) begin tests_failed++; $display("FAIL reset_first_grant got=%b exp=01", up_ready); end
      tick();
      clear_inputs();
      settle();
      tests_run++;
      if (dn_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_dn_valid got=%b exp=0", dn_valid); end
   endtask

   task automatic test_alternate();
      logic [NP-1:0] exp_ready;
      logic [NP-1:0] exp_rv;
      do_reset();
      drive_port(0, 1'b1, 1'b0, 32'h1000);
      drive_port(1, 1'b1, 1'b0, 32'h1004);
      dn_ready  = 1'b1;
      dn_rvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         dn_rdata  = 32'h50 + 32'(i);
         settle();
         exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
         exp_rv    = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
         tests_run++;
         if (up_ready !== exp_ready) begin tests_failed++; $display("FAIL alt_ready i=%0d got=%b exp=%b", i, up_ready, exp_ready); end
         tests_run++;
         if (dn_addr !== 32'h1000 + 32'((i % 2) * 4)) begin tests_failed++; $display("FAIL alt_addr i=%0d got=%h exp=%h", i, dn_addr, 32'h1000 + 32'((i % 2) * 4)); end
         tests_run++;
         if (up_rvalid !== exp_rv) begin tests_failed++; $display("FAIL alt_rvalid i=%0d got=%b exp=%b", i, up_rvalid, exp_rv); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_lock();
      do_reset();
      drive_port(0, 1'b1, 1'b1, 32'h50);
      dn_ready = 1'b1;
      settle();
      tests_run++;
      if (up_ready !== 2'b01) begin tests_failed++; $display("FAIL lock_pre_ready got=%b exp=01", up_ready); end
      tick();
      drive_port(0, 1'b1, 1'b1, 32'h200);
      dn_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) drive_port(1, 1'b1, 1'b1, 32'h300);
         if (c == 3) dn_ready = 1'b1;
         settle();
         tests_run++;
         if (dn_addr !== 32'h200) begin tests_failed++; $display("FAIL lock_addr c=%0d got=%h exp=00000200", c, dn_addr); end
         tests_run++;
         if (up_ready !== ((c == 3) ? 2'b01 : 2'b00)) begin tests_failed++; $display("FAIL lock_ready c=%0d got=%b exp=%b", c, up_ready, (c == 3) ? 2'b01 : 2'b00); end
         tick();
      end
      drive_port(0, 1'b0, 1'b1, 32'h0);
      settle();
      tests_run++;
      if (up_ready !== 2'b10) begin tests_failed++; $display("FAIL lock_next_ready got=%b exp=10", up_ready); end
      tests_run++;
      if (dn_addr !== 32'h300) begin tests_failed++; $display("FAIL lock_next_addr got=%h exp=00000300", dn_addr); end
      tick();
      clear_inputs();
   endtask

   task automatic test_order();
      do_reset();
      dn_ready = 1'b1;
      drive_port(1, 1'b1, 1'b0, 32'h100);
      settle();
      tests_run++;
      if (up_ready !== 2'b10) begin tests_failed++; $display("FAIL order_req1 got=%b exp=10", up_ready); end
      tick();
      drive_port(1, 1'b0, 1'b0, 32'h0);
      drive_port(0, 1'b1, 1'b0, 32'h200);
      settle();
      tests_run++;
      if (up_ready !== 2'b01) begin tests_failed++; $display("FAIL order_req0 got=%b exp=01", up_ready); end
      tick();
      drive_port(0, 1'b0, 1'b0, 32'h0);
      dn_rvalid = 1'b1;
      dn_rdata  = 32'hAAAA;
      settle();
      tests_run++;
      if (up_rvalid !== 2'b10) begin tests_failed++; $display("FAIL order_rsp1 got=%b exp=10", up_rvalid); end
      tests_run++;
      if (up_rdata !== 32'hAAAA) begin tests_failed++; $display("FAIL order_data1 got=%h exp=0000aaaa", up_rdata); end
      tick();
      dn_rdata = 32'hBBBB;
      settle();
      tests_run++;
      if (up_rvalid !== 2'b01) begin tests_failed++; $display("FAIL order_rsp0 got=%b exp=01", up_rvalid); end
      tests_run++;
      if (up_rdata !== 32'hBBBB) begin tests_failed++; $display("FAIL order_data0 got=%h exp=0000bbbb", up_rdata); end
      tick();
      dn_rdata = 32'hCCCC;
      settle();
      tests_run++;
      if (up_rvalid !== 2'b00) begin tests_failed++; $display("FAIL order_spurious got=%b exp=00", up_rvalid); end
      tick();
      clear_inputs();
   endtask

   task automatic test_full();
      do_reset();
      dn_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_port(0, 1'b1, 1'b0, 32'h400 + 32'(i * 4));
         settle();
         tests_run++;
         if (dn_valid !== (i < 4)) begin tests_failed++; $display("FAIL full_valid i=%0d got=%b exp=%b", i, dn_valid, i < 4); end
         tests_run++;
         if (up_ready !== ((i < 4) ? 2'b01 : 2'b00)) begin tests_failed++; $display("FAIL full_ready i=%0d got=%b exp=%b", i, up_ready, (i < 4) ? 2'b01 : 2'b00); end
         tick();
      end
      dn_rvalid = 1'b1;
      dn_rdata  = 32'h1234;
      settle();
      tests_run++;
      if (up_rvalid !== 2'b01) begin tests_failed++; $display("FAIL full_pop_rvalid got=%b exp=01", up_rvalid); end
      tests_run++;
      if (dn_valid !== 1'b0) begin tests_failed++; $display("FAIL full_pop_valid got=%b exp=0", dn_valid); end
      tick();
      dn_rvalid = 1'b0;
      settle();
      tests_run++;
      if (dn_valid !== 1'b1) begin tests_failed++; $display("FAIL full_after_pop got=%b exp=1", dn_valid); end
      tick();
      clear_inputs();
   endtask

   task automatic test_write_spurious();
      do_reset();
      dn_ready = 1'b1;
      drive_port(0, 1'b1, 1'b1, 32'h600);
      settle();
      tests_run++;
      if (up_ready !== 2'b01) begin tests_failed++; $display("FAIL wr_ready got=%b exp=01", up_ready); end
      tests_run++;
      if (dn_rw !== 1'b1) begin tests_failed++; $display("FAIL wr_rw got=%b exp=1", dn_rw); end
      tests_run++;
      if (dn_wdata !== ~32'h600) begin tests_failed++; $display("FAIL wr_wdata got=%h exp=%h", dn_wdata, ~32'h600); end
      tick();
      drive_port(0, 1'b0, 1'b0, 32'h0);
      dn_rvalid = 1'b1;
      dn_rdata  = 32'hDEAD;
      settle();
      tests_run++;
      if (up_rvalid !== 2'b00) begin tests_failed++; $display("FAIL wr_spurious got=%b exp=00", up_rvalid); end
      tick();
      dn_rvalid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_port(0, 1'b1, 1'b0, 32'h700 + 32'(i * 4));
         settle();
         tests_run++;
         if (dn_valid !== (i < 4)) begin tests_failed++; $display("FAIL wr_count i=%0d got=%b exp=%b", i, dn_valid, i < 4); end
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      dn_ready = 1'b1;
      drive_port(1, 1'b1, 1'b0, 32'h800);
      settle();
      tests_run++;
      if (up_ready !== 2'b10) begin tests_failed++; $display("FAIL mid_req1 got=%b exp=10", up_ready); end
      tick();
      drive_port(1, 1'b0, 1'b0, 32'h0);
      drive_port(0, 1'b1, 1'b0, 32'h804);
      settle();
      tests_run++;
      if (up_ready !== 2'b01) begin tests_failed++; $display("FAIL mid_req0 got=%b exp=01", up_ready); end
      tick();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      dn_rvalid = 1'b1;
      dn_rdata  = 32'h5555;
      dn_ready  = 1'b1;
      drive_port(0, 1'b1, 1'b0, 32'h900);
      drive_port(1, 1'b1, 1'b0, 32'h904);
      settle();
      tests_run++;
      if (up_rvalid !== 2'b00) begin tests_failed++; $display("FAIL mid_rvalid got=%b exp=00", up_rvalid); end
      tests_run++;
      if (up_ready !== 2'b01) begin tests_failed++; $display("FAIL mid_grant got=%b exp=01", up_ready); end
      tick();
      clear_inputs();
   endtask

   task automatic test_random();
      int            q[$];
      int            last;
      bit            locked;
      int            lock_port;
      bit            pend[NP];
      int            g;
      int            p;
      bit            exp_valid;
      logic [NP-1:0] exp_ready;
      logic [NP-1:0] exp_rv;
      do_reset();
      q         = {};
      last      = NP - 1;
      locked    = 1'b0;
      lock_port = 0;
      for (int i = 0; i < NP; i++) pend[i] = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < NP; i++) begin
            if (!pend[i]) begin
               if ($urandom_range(0, 1) == 1) begin
                  drive_port(i, 1'b1, 1'($urandom_range(0, 1)), $urandom);
                  pend[i] = 1'b1;
               end else begin
                  up_valid[i] = 1'b0;
               end
            end
         end
         dn_ready  = ($urandom_range(0, 2) != 0);
         dn_rvalid = ($urandom_range(0, 2) == 0);
         dn_rdata  = $urandom;
         settle();
         // Reference: who should be served and which requester owns the oldest read.
         exp_valid = (|up_valid) && (q.size() < MO) && !rst;
         g = -1;
         if (locked) begin
            g = lock_port;
         end else begin
            for (int k = 1; k <= NP; k++) begin
               p = (last + k) % NP;
               if (g < 0 && up_valid[p]) g = p;
            end
         end
         exp_ready = '0;
         if (exp_valid && dn_ready) exp_ready[g] = 1'b1;
         exp_rv = '0;
         if (!rst && dn_rvalid && q.size() > 0) exp_rv[q[0]] = 1'b1;
         tests_run++;
         if (dn_valid !== exp_valid) begin tests_failed++; $display("FAIL rand_dn_valid cyc=%0d got=%b exp=%b", cyc, dn_valid, exp_valid); end
         tests_run++;
         if (up_ready !== exp_ready) begin tests_failed++; $display("FAIL rand_up_ready cyc=%0d got=%b exp=%b", cyc, up_ready, exp_ready); end
         tests_run++;
         if (up_rvalid !== exp_rv) begin tests_failed++; $display("FAIL rand_up_rvalid cyc=%0d got=%b exp=%b", cyc, up_rvalid, exp_rv); end
         if (exp_valid) begin
            tests_run++;
            if (dn_addr !== up_addr[g*AL +: AL] || dn_rw !== up_rw[g] || dn_wmask !== up_wmask[g*DL +: DL]) begin
               tests_failed++;
               $display("FAIL rand_payload cyc=%0d got=%h/%b exp=%h/%b port=%0d", cyc, dn_addr, dn_rw, up_addr[g*AL +: AL], up_rw[g], g);
            end
         end
         if (exp_rv != '0) begin
            tests_run++;
            if (up_rdata !== dn_rdata) begin tests_failed++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, up_rdata, dn_rdata); end
         end
         tick();
         if (rst) begin
            q      = {};
            last   = NP - 1;
            locked = 1'b0;
         end else begin
            if (exp_rv != '0) void'(q.pop_front());
            if (exp_valid && dn_ready) begin
               last    = g;
               locked  = 1'b0;
               pend[g] = 1'b0;
               if (up_rw[g] == 1'b0) q.push_back(g);
            end else if (exp_valid) begin
               locked    = 1'b1;
               lock_port = g;
            end
         end
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      rst = 1'b1;
      tick();
      test_reset();
      test_alternate();
      test_lock();
      test_order();
      test_full();
      test_write_spurious();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
